imm_decode_ctrl: RTL and testbench
==================================

// Module: imm_decode_ctrl
// PURPOSE
//  Decode-stage sequencer for the immediate path. Accepts fetched 32-bit instructions over
//  valid/ready and classifies the opcode into an immediate format. Drives the external
//  imm_extender (imm_sel, inst) and registers the extended immediate with the instruction.
//  Two-stage pipeline (capture -> output) with stall back-pressure and flush; sits between
//  fetch and the register-read/execute stage.
// PARAMETERS
//  IW        32   instruction width; opcode = inst[IW-1:IW-5], operand field = inst[26:0]
//  CNT_W     16   width of per-format statistics counters (IMM_STATS_EN only)
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      fetch presents instruction
//  in_ready      out  1      decode can accept this cycle
//  in_inst       in   IW     fetched instruction
//  flush         in   1      kill all in-flight instructions (branch mispredict)
//  ext_imm_sel   out  2      to imm_extender: 00=17b, 01=22b, 11=26b, 10=none
//  ext_inst      out  27     to imm_extender: operand field of capture-stage instruction
//  ext_imm_out   in   32     from imm_extender: sign-extended immediate (combinational)
//  out_valid     out  1      decoded instruction available
//  out_ready     in   1      downstream accepts
//  out_inst      out  IW     decoded instruction
//  out_imm       out  32     extended immediate; 0 when format is none
//  out_has_imm   out  1      1 when out_imm is meaningful
//  stat_*        out  CNT_W  stat_imm17/imm22/imm26/none counters (IMM_STATS_EN only)
// BEHAVIOUR
//  - Reset: s0_valid=0, out_valid=0, out_inst=0, out_imm=0, out_has_imm=0, counters=0.
//    in_ready=1 in the cycle after reset. Reset overrides flush and all handshakes.
//  - Opcode class (op=inst[31:27]): 00xxx -> 17b (sel 00); 01xxx -> 22b (sel 01);
//    1100x -> 26b (sel 11); else none (sel 10).
//  - Stage S0 (capture): holds inst when in_valid&&in_ready. It drives ext_inst=s0_inst[26:0]
//    and ext_imm_sel from the S0 class every cycle.
//  - Stage S1 (output): loads s0_inst, ext_imm_out (or 0 when none), and has_imm when s1_adv.
//  - s1_adv = s0_valid && (!out_valid || out_ready); in_ready = !s0_valid || s1_adv
//    (combinational, no bubble at full throughput). Latency: accept in cycle N -> out_valid N+2.
//  - Throughput 1 instr/cycle when out_ready=1. With out_ready=0, both stages fill, then
//    in_ready=0. out_* are stable while out_valid && !out_ready.
//  - Handshake: out_valid never drops without out_ready, except on flush or rst.
//  - Flush: next cycle s0_valid=0 and out_valid=0. The same-cycle in_valid is not accepted
//    (in_ready forced 0 while flush=1). out_inst/out_imm keep their old values (don't care).
//  - Simultaneous out accept and S1 load: new data replaces the old. Simultaneous S0 accept and
//    S0->S1 move: S0 takes the new instruction.
//  - ext_* with s0_valid=0: ext_imm_sel=10, ext_inst=0 (quiet extender inputs).
// CONFIGURATION
//  IMM_STATS_EN defined: four saturating CNT_W counters increment on each S1 load by class.
//    Counters saturate at all-ones, are cleared by rst, and are not cleared by flush.
//  IMM_STATS_EN undefined: no counters and no stat_* ports; other behaviour identical.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, out_imm=0, in_ready=1 on the first cycle after release.
//  2. in_inst={5'b00000,27'h0010000}, out_ready=1 -> 2 cycles later out_imm=32'hFFFF0000,
//     out_has_imm=1. Then operand 27'h0008000 -> 32'h00008000.
//  3. Back-to-back op 01000/27'h0200000, op 11000/27'h2000000, op 11100/any, out_ready=1
//     -> consecutive outputs FFE00000, FE000000, imm=0 with has_imm=0; no bubbles.
//  4. out_ready=0 with 3 instrs offered -> 2 accepted, in_ready=0, out_* stable. Release
//     -> all 3 emerge in order.
//  5. flush with both stages full and in_valid=1 -> next cycle out_valid=0, s0 empty; the
//     flushed-cycle instr is not accepted (re-offered, then emerges 2 cycles after acceptance).
//  6. IMM_STATS_EN: 5x17b, 2x26b, 1 none -> stat_imm17=5, stat_imm26=2, stat_none=1; flush
//     mid-stream leaves counts.

Source files
------------

// File: rtl/imm_decode_ctrl.sv
// Decode-stage immediate sequencer: capture (S0) -> output (S1) pipeline driving an external imm_extender.
// Optional per-format saturating statistics counters are enabled by defining IMM_STATS_EN.
module imm_decode_ctrl #(
  parameter int IW = 32
`ifdef IMM_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_inst,
  input  logic          flush,
  output logic [1:0]    ext_imm_sel,
  output logic [26:0]   ext_inst,
  input  logic [31:0]   ext_imm_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_inst,
  output logic [31:0]   out_imm,
  output logic          out_has_imm
`ifdef IMM_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_imm17,
  output logic [CNT_W-1:0] stat_imm22,
  output logic [CNT_W-1:0] stat_imm26,
  output logic [CNT_W-1:0] stat_none
`endif
);

  localparam logic [1:0] SEL_17   = 2'b00;
  localparam logic [1:0] SEL_22   = 2'b01;
  localparam logic [1:0] SEL_26   = 2'b11;
  localparam logic [1:0] SEL_NONE = 2'b10;

  function automatic logic [1:0] classify(input logic [4:0] op);
    logic [1:0] sel;
    sel = SEL_NONE;
    if (op[4:3] == 2'b00)        sel = SEL_17;
    else if (op[4:3] == 2'b01)   sel = SEL_22;
    else if (op[4:1] == 4'b1100) sel = SEL_26;
    return sel;
  endfunction

  logic          s0_valid_q, s0_valid_d;
  logic [IW-1:0] s0_inst_q, s0_inst_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_inst_q, out_inst_d;
  logic [31:0]   out_imm_q, out_imm_d;
  logic          out_has_imm_q, out_has_imm_d;

  logic [1:0] s0_sel;
  logic       s1_adv;
  logic       s1_load;
  logic       s0_accept;

  assign s0_sel    = classify(s0_inst_q[IW-1:IW-5]);
  assign s1_adv    = s0_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !flush && (!s0_valid_q || s1_adv);
  assign s0_accept = in_valid && in_ready;
  // A flushed cycle never loads S1, so output data and statistics ignore killed work.
  assign s1_load   = s1_adv && !flush;

  assign ext_imm_sel = s0_valid_q ? s0_sel : SEL_NONE;
  assign ext_inst    = s0_valid_q ? s0_inst_q[26:0] : 27'd0;

  always_comb begin
    s0_valid_d    = s0_valid_q;
    s0_inst_d     = s0_inst_q;
    out_valid_d   = out_valid_q;
    out_inst_d    = out_inst_q;
    out_imm_d     = out_imm_q;
    out_has_imm_d = out_has_imm_q;
    if (flush) begin
      s0_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s0_accept) begin
        s0_valid_d = 1'b1;
        s0_inst_d  = in_inst;
      end else if (s1_adv) begin
        s0_valid_d = 1'b0;
      end
      if (s1_load) begin
        out_valid_d   = 1'b1;
        out_inst_d    = s0_inst_q;
        out_has_imm_d = (s0_sel != SEL_NONE);
        out_imm_d     = (s0_sel != SEL_NONE) ? ext_imm_out : 32'd0;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q    <= 1'b0;
      s0_inst_q     <= '0;
      out_valid_q   <= 1'b0;
      out_inst_q    <= '0;
      out_imm_q     <= 32'd0;
      out_has_imm_q <= 1'b0;
    end else begin
      s0_valid_q    <= s0_valid_d;
      s0_inst_q     <= s0_inst_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_imm_q     <= out_imm_d;
      out_has_imm_q <= out_has_imm_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_imm     = out_imm_q;
  assign out_has_imm = out_has_imm_q;

`ifdef IMM_STATS_EN
  // Counter slot gi counts the class whose select code sits at CNT_SEL_MAP[2*gi +: 2].
  localparam logic [7:0] CNT_SEL_MAP = {SEL_NONE, SEL_26, SEL_22, SEL_17};

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    localparam logic [1:0] CNT_SEL = CNT_SEL_MAP[2*gi +: 2];
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (s1_load && (s0_sel == CNT_SEL) && (cnt_q[gi] != {CNT_W{1'b1}}))
        cnt_d[gi] = cnt_q[gi] + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q[gi] <= '0;
      else     cnt_q[gi] <= cnt_d[gi];
    end
  end

  assign stat_imm17 = cnt_q[0];
  assign stat_imm22 = cnt_q[1];
  assign stat_imm26 = cnt_q[2];
  assign stat_none  = cnt_q[3];
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl with a behavioural imm_extender; define IMM_STATS_EN to cover the counters.
module tb_imm_decode_ctrl;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        flush;
  logic [1:0]  ext_imm_sel;
  logic [26:0] ext_inst;
  logic [31:0] ext_imm_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_imm;
  logic        out_has_imm;
`ifdef IMM_STATS_EN
  logic [15:0] stat_imm17, stat_imm22, stat_imm26, stat_none;
`endif

  int checks = 0;
  int errors = 0;

  imm_decode_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .ext_imm_sel(ext_imm_sel), .ext_inst(ext_inst), .ext_imm_out(ext_imm_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_imm(out_imm),
    .out_has_imm(out_has_imm)
`ifdef IMM_STATS_EN
    , .stat_imm17(stat_imm17), .stat_imm22(stat_imm22), .stat_imm26(stat_imm26), .stat_none(stat_none)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Extender model; "none" returns garbage so the DUT's zeroing is observable.
  always_comb begin
    case (ext_imm_sel)
      2'b00:   ext_imm_out = {{15{ext_inst[16]}}, ext_inst[16:0]};
      2'b01:   ext_imm_out = {{10{ext_inst[21]}}, ext_inst[21:0]};
      2'b11:   ext_imm_out = {{6{ext_inst[25]}}, ext_inst[25:0]};
      default: ext_imm_out = 32'hDEADBEEF;
    endcase
  end

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
    checks++; if (out_has_imm !== 1'b0) begin errors++; $display("FAIL reset_has_imm got %b want 0", out_has_imm); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    checks++; if (ext_imm_sel !== 2'b10 || ext_inst !== 27'h0) begin
      errors++; $display("FAIL reset_ext got sel=%b inst=%h want sel=10 inst=0", ext_imm_sel, ext_inst);
    end
    $display("test_reset done");
  endtask

  task automatic test_imm17;
    logic [31:0] a, b;
    a = {5'b00000, 27'h0010000};
    b = {5'b00000, 27'h0008000};
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL imm17_ready got %b want 1", in_ready); end
    in_valid = 1'b1; in_inst = a;
    @(negedge clk);
    checks++; if (ext_imm_sel !== 2'b00 || ext_inst !== 27'h0010000) begin
      errors++; $display("FAIL imm17_ext got sel=%b inst=%h want sel=00 inst=0010000", ext_imm_sel, ext_inst);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL imm17_latency got out_valid=%b want 0", out_valid); end
    in_inst = b;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFF0000 || out_has_imm !== 1'b1 || out_inst !== a) begin
      errors++; $display("FAIL imm17_neg got v=%b imm=%h has=%b inst=%h want v=1 imm=ffff0000 has=1 inst=%h",
                         out_valid, out_imm, out_has_imm, out_inst, a);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'h00008000 || out_has_imm !== 1'b1 || out_inst !== b) begin
      errors++; $display("FAIL imm17_pos got v=%b imm=%h has=%b inst=%h want v=1 imm=00008000 has=1 inst=%h",
                         out_valid, out_imm, out_has_imm, out_inst, b);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL imm17_drain got out_valid=%b want 0", out_valid); end
    $display("test_imm17 done");
  endtask

  task automatic test_back_to_back;
    logic [31:0] insts [3];
    logic [31:0] imms  [3];
    logic        has   [3];
    insts[0] = {5'b01000, 27'h0200000}; imms[0] = 32'hFFE00000; has[0] = 1'b1;
    insts[1] = {5'b11000, 27'h2000000}; imms[1] = 32'hFE000000; has[1] = 1'b1;
    insts[2] = {5'b11100, 27'h1234567}; imms[2] = 32'h00000000; has[2] = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_inst !== insts[c-2] || out_imm !== imms[c-2] || out_has_imm !== has[c-2]) begin
          errors++; $display("FAIL b2b_out%0d got v=%b inst=%h imm=%h has=%b want v=1 inst=%h imm=%h has=%b",
                             c-2, out_valid, out_inst, out_imm, out_has_imm, insts[c-2], imms[c-2], has[c-2]);
        end
      end
      if (c == 5) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid); end
      end
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", c, in_ready); end
        in_valid = 1'b1; in_inst = insts[c];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall;
    logic [31:0] i0, i1, i2;
    i0 = {5'b00000, 27'h0000005};
    i1 = {5'b01111, 27'h03FFFFF};
    i2 = {5'b11001, 27'h7ABCDEF};
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = i0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %b want 1", in_ready); end
    in_inst = i1;
    @(negedge clk);
    in_inst = i2;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== i0 || out_imm !== 32'h5 || out_has_imm !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got rdy=%b v=%b inst=%h imm=%h want rdy=0 v=1 inst=%h imm=00000005",
                           c, in_ready, out_valid, out_inst, out_imm, i0);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_inst !== i1 || out_imm !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL stall_out1 got v=%b inst=%h imm=%h want v=1 inst=%h imm=ffffffff", out_valid, out_inst, out_imm, i1);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_inst !== i2 || out_imm !== 32'hFFABCDEF) begin
      errors++; $display("FAIL stall_out2 got v=%b inst=%h imm=%h want v=1 inst=%h imm=ffabcdef", out_valid, out_inst, out_imm, i2);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got out_valid=%b want 0", out_valid); end
    $display("test_stall done");
  endtask

  task automatic test_flush;
    logic [31:0] j0, j1, j2;
    j0 = {5'b01000, 27'h0000001};
    j1 = {5'b11000, 27'h0000002};
    j2 = {5'b00111, 27'h000FFFF};
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = j0;
    @(negedge clk);
    in_inst = j1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_full got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
    end
    flush = 1'b1; in_inst = j2;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || ext_imm_sel !== 2'b10 || ext_inst !== 27'h0) begin
      errors++; $display("FAIL flush_empty got v=%b sel=%b inst=%h want v=0 sel=10 inst=0", out_valid, ext_imm_sel, ext_inst);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_reoffer_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || ext_imm_sel !== 2'b00 || ext_inst !== 27'h000FFFF) begin
      errors++; $display("FAIL flush_s0 got v=%b sel=%b inst=%h want v=0 sel=00 inst=000ffff", out_valid, ext_imm_sel, ext_inst);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_inst !== j2 || out_imm !== 32'h0000FFFF || out_has_imm !== 1'b1) begin
      errors++; $display("FAIL flush_out got v=%b inst=%h imm=%h has=%b want v=1 inst=%h imm=0000ffff has=1",
                         out_valid, out_inst, out_imm, out_has_imm, j2);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got out_valid=%b want 0", out_valid); end
    $display("test_flush done");
  endtask

`ifdef IMM_STATS_EN
  task automatic test_stats;
    logic [4:0] ops [8];
    ops[0] = 5'b00000; ops[1] = 5'b00011; ops[2] = 5'b11000; ops[3] = 5'b00101;
    ops[4] = 5'b10101; ops[5] = 5'b00111; ops[6] = 5'b11001; ops[7] = 5'b00001;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (stat_imm17 !== 16'd0 || stat_none !== 16'd0) begin
      errors++; $display("FAIL stats_reset got s17=%0d none=%0d want 0 0", stat_imm17, stat_none);
    end
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_inst = {ops[c], 27'h0000010};
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (stat_imm17 !== 16'd5 || stat_imm22 !== 16'd0 || stat_imm26 !== 16'd2 || stat_none !== 16'd1) begin
      errors++; $display("FAIL stats_counts got s17=%0d s22=%0d s26=%0d none=%0d want 5 0 2 1",
                         stat_imm17, stat_imm22, stat_imm26, stat_none);
    end
    in_valid = 1'b1; in_inst = {5'b01010, 27'h0000001};
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (stat_imm17 !== 16'd5 || stat_imm22 !== 16'd0 || stat_imm26 !== 16'd2 || stat_none !== 16'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stats_flush got s17=%0d s22=%0d s26=%0d none=%0d v=%b want 5 0 2 1 v=0",
                         stat_imm17, stat_imm22, stat_imm26, stat_none, out_valid);
    end
    $display("test_stats done");
  endtask
`endif

  initial begin
    test_reset();
    test_imm17();
    test_back_to_back();
    test_stall();
    test_flush();
`ifdef IMM_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
